// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: port identifiers, starvation
// limit default and counter width.
package dmem_arb_pkg;

  localparam logic PORT_CPU       = 1'b0;
  localparam logic PORT_DMA       = 1'b1;
  localparam int   STARVE_MAX_DEF = 4;
  localparam int   CNT_W          = 4;

  // Byte enables only carry meaning for writes; reads present all-zero enables.
  function automatic logic [3:0] eff_be(input logic we, input logic [3:0] be);
    return we ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the low-priority port; raises force_gnt
// once the port has been refused STARVE_MAX consecutive cycles.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic lose,
  input  logic win,
  output logic force_gnt
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // A dropped request or a win restarts the wait from zero.
  always_comb begin
    cnt_nxt = cnt;
    if (!req || win) begin
      cnt_nxt = '0;
    end else if (lose && (cnt != MAX)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign force_gnt = req && (cnt == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port synchronous-read data memory: CPU has
// fixed priority, the DMA/loader port is forced through after bounded starvation.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 11,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock_i,
  input  logic          reset_ni,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [31:0]   m0_wdata_i,
  input  logic [3:0]    m0_be_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [31:0]   m0_rdata_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [31:0]   m1_wdata_i,
  input  logic [3:0]    m1_be_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [31:0]   m1_rdata_o,

  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [31:0]   mem_rdata_i
);

  logic        force_gnt;
  logic        resp_v;
  logic        resp_id;
  logic        resp_we;
  logic [31:0] resp_rdata;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clock_i),
    .rst_n    (reset_ni),
    .req      (m1_req_i),
    .lose     (m0_gnt_o),
    .win      (m1_gnt_o),
    .force_gnt(force_gnt)
  );

  // Grant stage: purely combinational, so the CPU can use m0_gnt_o as its stall qualifier.
  assign m1_gnt_o = force_gnt || (!m0_req_i && m1_req_i);
  assign m0_gnt_o = m0_req_i && !force_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (m1_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_be_o    = eff_be(m1_we_i, m1_be_i);
    end else if (m0_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_be_o    = eff_be(m0_we_i, m0_be_i);
    end
  end

  // Response stage: one cycle behind the grant, aligned with the memory read data.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      resp_v  <= 1'b0;
      resp_id <= PORT_CPU;
      resp_we <= 1'b0;
    end else begin
      resp_v <= mem_en_o;
      if (mem_en_o) begin
        resp_id <= m1_gnt_o ? PORT_DMA : PORT_CPU;
        resp_we <= mem_we_o;
      end
    end
  end

  assign resp_rdata  = resp_we ? 32'h0 : mem_rdata_i;
  assign m0_rvalid_o = resp_v && (resp_id == PORT_CPU);
  assign m1_rvalid_o = resp_v && (resp_id == PORT_DMA);
  assign m0_rdata_o  = resp_rdata;
  assign m1_rdata_o  = resp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbitration model predicts
// grants/strobes each cycle and queues the expected response for the next one.
module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int SM = 4;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_be, m1_be;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  logic [31:0] mem     [2**AW];
  logic [31:0] ref_mem [2**AW];
  resp_t       sb[$];
  int          m_cnt;
  logic        last_g0, last_g1;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
    .clock_i    (clk),
    .reset_ni   (reset_ni),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_be_i    (m0_be),
    .m0_gnt_o   (m0_gnt),
    .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o (m0_rdata),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_be_i    (m1_be),
    .m1_gnt_o   (m1_gnt),
    .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o (m1_rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous-read memory macro model
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check last cycle's response, predict this cycle's grant.
  task automatic step();
    resp_t         e;
    logic          frc, g0, g1, we;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic [3:0]    be;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid0", m0_rvalid, e.port == 1'b0);
      chk("rvalid1", m1_rvalid, e.port == 1'b1);
      chk("rdata", e.port ? m1_rdata : m0_rdata, e.data);
    end else begin
      chk("rvalid0_idle", m0_rvalid, 0);
      chk("rvalid1_idle", m1_rvalid, 0);
    end
    chk("starve_cnt", dut.u_starve.cnt, m_cnt);
    frc = m1_req && (m_cnt == SM);
    g1  = frc || (!m0_req && m1_req);
    g0  = m0_req && !frc;
    chk("gnt0", m0_gnt, g0);
    chk("gnt1", m1_gnt, g1);
    chk("mem_en", mem_en, g0 || g1);
    if (g0 || g1) begin
      we = g1 ? m1_we    : m0_we;
      a  = g1 ? m1_addr  : m0_addr;
      wd = g1 ? m1_wdata : m0_wdata;
      be = g1 ? m1_be    : m0_be;
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, a);
      chk("mem_be", mem_be, we ? be : 4'b0000);
      if (we) chk("mem_wdata", mem_wdata, wd);
      sb.push_back('{port: g1, we: we, data: we ? 32'h0 : ref_mem[a]});
      if (we)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    end else begin
      chk("mem_we_idle", mem_we, 0);
      chk("mem_be_idle", mem_be, 0);
      chk("mem_addr_idle", mem_addr, 0);
      chk("mem_wdata_idle", mem_wdata, 0);
    end
    if (!m1_req || g1) m_cnt = 0;
    else if (g0 && m_cnt < SM) m_cnt++;
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n1, first, refused;
    logic got;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    end
    mem[11'h010]     = 32'hDEADBEEF;
    ref_mem[11'h010] = 32'hDEADBEEF;
    m_cnt    = 0;
    reset_ni = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    chk("rst_cnt", dut.u_starve.cnt, 0);
    @(posedge clk);
    #1 reset_ni = 1'b1;

    // CPU read of DEADBEEF
    m0_req = 1; m0_we = 0; m0_addr = 11'h010;
    step();
    m0_req = 0;
    step();

    // DMA partial write
    m1_req = 1; m1_we = 1; m1_addr = 11'h020; m1_wdata = 32'h12345678; m1_be = 4'b0011;
    step();
    m1_req = 0;
    step();

    // CPU back-to-back reads (third one reads the partially written word)
    m0_req = 1;
    for (int i = 0; i < 3; i++) begin
      m0_addr = 11'h01E + AW'(i);
      step();
    end
    m0_req = 0;
    step();

    // Both ports saturated: DMA gets exactly every fifth slot
    m0_req = 1; m0_we = 0; m0_addr = 11'h100;
    m1_req = 1; m1_we = 1; m1_addr = 11'h040; m1_wdata = 32'hCAFEF00D; m1_be = 4'b1111;
    n1 = 0; first = -1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (last_g1) begin
        if (first < 0) first = i;
        n1++;
        m1_addr  = 11'h040 + AW'(n1);
        m1_wdata = $urandom;
        m1_be    = 4'($urandom_range(1, 15));
      end
      if (last_g0) m0_addr = AW'($urandom);
    end
    chk("dma_share", n1, 3);
    chk("first_dma_slot", first, 4);
    m0_req = 0; m1_req = 0;
    step();

    // Read back what the DMA wrote
    m0_req = 1; m0_we = 0;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 11'h040 + AW'(i);
      step();
    end
    m0_req = 0;
    step();

    // Dropping the request restarts the starvation count
    m0_req = 1; m0_addr = 11'h055;
    m1_req = 1; m1_we = 0; m1_addr = 11'h005;
    repeat (3) step();
    m1_req = 0;
    step();
    m1_req = 1;
    refused = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (last_g1) got = 1;
      else refused++;
    end
    chk("starve_got", got, 1);
    chk("starve_restart", refused, 4);
    m0_req = 0; m1_req = 0;
    step();

    // Reset with a read response in flight and a non-zero counter
    m0_req = 1; m0_addr = 11'h010;
    m1_req = 1;
    repeat (2) step();
    m0_req = 0; m1_req = 0;
    reset_ni = 1'b0;
    sb.delete();
    m_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_rvalid0", m0_rvalid, 0);
      chk("rstmid_rvalid1", m1_rvalid, 0);
      chk("rstmid_cnt", dut.u_starve.cnt, 0);
    end
    @(posedge clk);
    #1 reset_ni = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, synchronous-read data memory behind the load/store unit between the CPU (port 0) and a program loader/DMA requester (port 1). Port 0 has fixed priority. A starvation counter guarantees port 1 a slot after a bounded wait. The block sits between the LSU memory strobes and the memory macro, and its port-0 grant doubles as the CPU stall qualifier.

## Interface
Parameters:
- AW, 11, word address width of the shared memory.
- STARVE_MAX, 4, number of consecutive cycles port 1 may be refused while requesting before it is forced through (range 1..15).

Ports (N = 0, 1):
- clock_i  in  1  system clock, all state updates on the rising edge.
- reset_ni  in  1  reset; asynchronous, active-low.
- mN_req_i  in  1  request; must stay high with stable fields until mN_gnt_o.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_addr_i  in  AW  word address.
- mN_wdata_i  in  32  write data.
- mN_be_i  in  4  byte enables for writes; ignored for reads.
- mN_gnt_o  out  1  request accepted this cycle (combinational).
- mN_rvalid_o  out  1  response for the previously granted request of this port (registered).
- mN_rdata_o  out  32  read data; valid only with mN_rvalid_o.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_be_o  out  4  memory byte enables.
- mem_rdata_i  in  32  memory read data; the memory drives it one cycle after mem_en_o with mem_we_o = 0.

## Operation
Grant rule, evaluated every cycle:
- force = m1_req_i && (starve_cnt == STARVE_MAX).
- If force: port 1 is granted.
- Otherwise, if m0_req_i: port 0 is granted.
- Otherwise, if m1_req_i: port 1 is granted.
- Otherwise: no grant.
- At most one mN_gnt_o is high per cycle.

Memory strobes:
- mem_en_o = any grant.
- mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are muxed from the granted port.
- When there is no grant, all strobes are 0.
- mem_be_o is forced to 4'b0000 on reads.

Starvation counter (4 bits):
- Cleared when port 1 is granted or m1_req_i is low.
- Incremented when m1_req_i is high and port 0 is granted.
- Saturates at STARVE_MAX.

Response tracker:
- Registers resp_v, resp_id and resp_we on every grant.
- mN_rvalid_o = resp_v && resp_id == N. It is asserted for writes too, as an acknowledge.
- mN_rdata_o = mem_rdata_i when resp_we = 0, otherwise 32'h0.
- A port may be re-granted in the cycle its rvalid is high; full throughput is one access per cycle.

## Timing
- Grant latency is zero: mN_req_i high in cycle N produces mN_gnt_o and the memory strobes in cycle N.
- The response arrives in cycle N+1: mN_rvalid_o is high and mN_rdata_o equals mem_rdata_i.
- Reset values: starve_cnt = 0, resp_v = 0, every mN_rvalid_o = 0.
- With all requests low during reset, every output is 0.
- Reset asserted mid-operation drops any pending response: no rvalid is produced after reset deassertion.
- Simultaneous requests with starve_cnt < STARVE_MAX: port 0 wins, port 1 waits and its counter increments.
- Simultaneous requests with starve_cnt == STARVE_MAX: port 1 wins, port 0 sees m0_gnt_o = 0 (CPU stalls one cycle), and the counter clears.
- Port 1 dropping its request while starved clears the counter; no force is pending afterwards.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - Port ID constants PORT_CPU = 1'b0 and PORT_DMA = 1'b1.
  - The default STARVE_MAX.
  - The counter width constant (4).
- One natural sub-module, `arb_starve_ctr`: the saturating starvation counter with inputs req/lose/win and output `force`.
- The grant mux and response tracker stay in the top module.

## Test plan
- Port 0 only, read at addr 11'h010 with memory returning 32'hDEADBEEF:
  - Cycle 0: m0_gnt_o = 1, mem_en_o = 1, mem_we_o = 0.
  - Cycle 1: m0_rvalid_o = 1, m0_rdata_o = 32'hDEADBEEF.
- Port 1 only, write 32'h12345678 to addr 11'h020 with be 4'b0011:
  - Same cycle: mem_we_o = 1, mem_be_o = 4'b0011, mem_wdata_o = 32'h12345678.
  - Next cycle: m1_rvalid_o = 1, m1_rdata_o = 0.
- Both ports request continuously with STARVE_MAX = 4:
  - Port 0 is granted in cycles 0–3.
  - Port 1 is granted in cycle 4, then port 0 in cycles 5–8, repeating: exactly 1 port-1 grant per 5 cycles.
- Port 0 back-to-back reads to 3 addresses in 3 cycles: 3 consecutive rvalid pulses in cycles 1–3, each with the matching data.
- Starvation reset: port 1 refused 3 cycles, drops its request 1 cycle, then re-requests alongside port 0. Required: port 1 is not granted until 4 further refusals (counter restarted from 0).
- Reset mid-operation: grant a read in cycle 0, pull reset_ni low in cycle 1 before the edge. Required: m0_rvalid_o = 0 throughout reset and after release, and starve_cnt = 0.
